// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment codes and bit positions for the seven-segment scanner
package seg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Logical (active-high) patterns for hex digits 0..F; index is the nibble value.
  localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-high segment pattern
import seg_pkg::*;

module seg_hex_decode (
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_CODES[nibble];
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed multi-digit seven-segment driver with double buffering
import seg_pkg::*;

module seg_scan #(
  parameter int DIGITS         = 8,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_suppress,
  output logic [SEG_W-1:0]      seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Physical-level inversion masks applied at the output register.
  localparam logic [SEG_W-1:0]  SEG_XOR = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_XOR = {DIGITS{SEL_ACTIVE_LOW}};

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic                wrap;
  logic                boundary;

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [4*DIGITS-1:0] act_value;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   act_blank;

  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic [SEG_W-1:0]    dec_seg;
  logic                dark;
  logic [DIGITS-1:0]   sel_onehot;

  logic [SEG_W-1:0]    seg_l;
  logic                dp_l;
  logic [DIGITS-1:0]   sel_l;

  assign wrap     = en && (div_cnt == DIV_LAST);
  assign boundary = wrap && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (en) begin
      if (wrap) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // A load coinciding with the boundary bypasses the shadow so it is not held a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      act_value <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      pending   <= 1'b0;
    end else if (load && boundary) begin
      sh_value  <= value;
      sh_dp     <= dp_in;
      sh_blank  <= blank_in;
      act_value <= value;
      act_dp    <= dp_in;
      act_blank <= blank_in;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        pending   <= 1'b0;
      end
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        pending  <= 1'b1;
      end
    end
  end

  // Walk down from the most significant digit while every digit seen so far is zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (act_value[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign cur_nib    = act_value[{idx, 2'b00} +: 4];
  assign dark       = act_blank[idx] | (lz_suppress & lz_mask[idx]);
  assign sel_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

  seg_hex_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_l = SEG_OFF;
    dp_l  = 1'b0;
    sel_l = '0;
    if (en) begin
      seg_l = dark ? SEG_OFF : dec_seg;
      dp_l  = act_dp[idx] & ~act_blank[idx];
      sel_l = (div_cnt == '0) ? '0 : sel_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= SEG_OFF ^ SEG_XOR;
      seg_dp     <= SEG_ACTIVE_LOW;
      sel        <= SEL_XOR;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_l ^ SEG_XOR;
      seg_dp     <= dp_l ^ SEG_ACTIVE_LOW;
      sel        <= sel_l ^ SEL_XOR;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan with a frame-time reference model
module tb_seg_scan;

  localparam int DG = 4;
  localparam int DV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;

  logic [6:0]  d_seg;
  logic        d_dp;
  logic [3:0]  d_sel;
  logic        d_fd;
  logic        d_pend;
  logic [6:0]  i_seg;
  logic        i_dp;
  logic [3:0]  i_sel;
  logic        i_fd;
  logic        i_pend;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(DG), .DIV(DV), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg(d_seg), .seg_dp(d_dp),
    .sel(d_sel), .frame_done(d_fd), .pending(d_pend)
  );

  seg_scan #(.DIGITS(DG), .DIV(DV), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg(i_seg), .seg_dp(i_dp),
    .sel(i_sel), .frame_done(i_fd), .pending(i_pend)
  );

  logic [6:0] ref_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: scan position derived from the count of enabled cycles since reset.
  int          m_t;
  logic [15:0] m_sh_val, m_ac_val;
  logic [3:0]  m_sh_dp, m_ac_dp, m_sh_bl, m_ac_bl;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_sel;
  logic        e_fd;
  logic        e_pend;

  always @(posedge clk) begin : model
    int   pos;
    int   d;
    bit   bnd;
    bit   lead;
    int   nib;
    if (!rst_n) begin
      m_t = 0;
      m_sh_val = 16'h0; m_ac_val = 16'h0;
      m_sh_dp = 4'h0;   m_ac_dp = 4'h0;
      m_sh_bl = 4'hF;   m_ac_bl = 4'hF;
      m_pend = 1'b0;
      e_seg = 7'h00; e_dp = 1'b0; e_sel = 4'h0; e_fd = 1'b0; e_pend = 1'b0;
    end else begin
      pos = m_t % DV;
      d   = (m_t / DV) % DG;
      bnd = en && (pos == DV - 1) && (d == DG - 1);
      if (!en) begin
        e_seg = 7'h00; e_dp = 1'b0; e_sel = 4'h0;
      end else begin
        nib  = int'((m_ac_val >> (4 * d)) & 16'hF);
        lead = 1'b1;
        for (int j = d; j < DG; j++)
          if (((m_ac_val >> (4 * j)) & 16'hF) != 16'h0) lead = 1'b0;
        if (m_ac_bl[d] || (lz_suppress && d != 0 && lead)) e_seg = 7'h00;
        else e_seg = ref_tbl[nib];
        e_dp  = m_ac_bl[d] ? 1'b0 : m_ac_dp[d];
        e_sel = (pos == 0) ? 4'h0 : 4'(1 << d);
      end
      e_fd = bnd;
      if (load && bnd) begin
        m_ac_val = value; m_ac_dp = dp_in; m_ac_bl = blank_in;
        m_sh_val = value; m_sh_dp = dp_in; m_sh_bl = blank_in;
        m_pend = 1'b0;
      end else begin
        if (bnd && m_pend) begin
          m_ac_val = m_sh_val; m_ac_dp = m_sh_dp; m_ac_bl = m_sh_bl;
          m_pend = 1'b0;
        end
        if (load) begin
          m_sh_val = value; m_sh_dp = dp_in; m_sh_bl = blank_in;
          m_pend = 1'b1;
        end
      end
      e_pend = m_pend;
      if (en) m_t++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [6:0] inv_seg;
    logic [3:0] inv_sel;
    @(negedge clk);
    if (chk_en) begin
      inv_seg = ~e_seg;
      inv_sel = ~e_sel;
      chk("seg", d_seg, e_seg);
      chk("seg_dp", d_dp, e_dp);
      chk("sel", d_sel, e_sel);
      chk("frame_done", d_fd, e_fd);
      chk("pending", d_pend, e_pend);
      chk("inv_seg", i_seg, inv_seg);
      chk("inv_dp", i_dp, !e_dp);
      chk("inv_sel", i_sel, inv_sel);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    load = 1'b1; value = v; dp_in = dp; blank_in = bl;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_fd();
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (d_fd) found = 1'b1;
    end
    chk("frame_done_seen", found, 1'b1);
  endtask

  // Called on a frame_done cycle; walks the next frame and ends on its frame_done.
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
    for (int d = 0; d < DG; d++) begin
      for (int p = 0; p < DV; p++) begin
        tick();
        chk({tag, "_sel"}, d_sel, (p == 0) ? 32'h0 : (32'h1 << d));
        chk({tag, "_seg"}, d_seg, segs[7*d +: 7]);
        chk({tag, "_dp"}, d_dp, dps[d]);
      end
    end
    chk({tag, "_fd"}, d_fd, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0;
    dp_in = 4'h0; blank_in = 4'h0; lz_suppress = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_sel", d_sel, 4'h0);
    chk("rst_seg", d_seg, 7'h00);
    chk("rst_fd", d_fd, 1'b0);
    chk("rst_pend", d_pend, 1'b0);
    chk("rst_inv_sel", i_sel, 4'hF);
    chk("rst_inv_seg", i_seg, 7'h7F);
    chk("rst_inv_dp", i_dp, 1'b1);
    chk_en = 1'b1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("dark_after_reset", d_seg, 7'h00);
    end

    // Load and scan
    do_load(16'h12AF, 4'h0, 4'h0);
    chk("pend_after_load", d_pend, 1'b1);
    wait_fd();
    chk("pend_after_xfer", d_pend, 1'b0);
    check_frame({7'h06, 7'h5B, 7'h77, 7'h71}, 4'h0, "scan");

    // Tear-free update mid-frame
    ticks(5);
    do_load(16'h0003, 4'h0, 4'h0);
    chk("tear_pend", d_pend, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (d_sel == 4'b0100) chk("tear_old_d2", d_seg, 7'h5B);
      if (d_sel == 4'b1000) chk("tear_old_d3", d_seg, 7'h06);
      if (d_fd) found = 1'b1;
    end
    chk("tear_fd_seen", found, 1'b1);
    chk("tear_pend_clear", d_pend, 1'b0);
    check_frame({7'h3F, 7'h3F, 7'h3F, 7'h4F}, 4'h0, "tear");

    // Leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'b1000, 4'h0);
    wait_fd();
    check_frame({7'h00, 7'h00, 7'h4F, 7'h3F}, 4'b1000, "lz");
    do_load(16'h0000, 4'h0, 4'h0);
    wait_fd();
    check_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0, "lz0");

    // Polarity and blanking on the inverted instance
    lz_suppress = 1'b0;
    do_load(16'h8888, 4'h0, 4'b0100);
    wait_fd();
    for (int d = 0; d < DG; d++) begin
      for (int p = 0; p < DV; p++) begin
        tick();
        chk("pol_sel", i_sel, (p == 0) ? 32'hF : (~(32'h1 << d) & 32'hF));
        chk("pol_seg", i_seg, (d == 2) ? 32'h7F : 32'h00);
        chk("pol_dp", i_dp, 1'b1);
      end
    end
    chk("pol_fd", i_fd, 1'b1);

    // Load on the boundary cycle itself
    ticks(15);
    load = 1'b1; value = 16'h4321; dp_in = 4'h0; blank_in = 4'h0;
    tick();
    load = 1'b0;
    chk("coll_fd", d_fd, 1'b1);
    chk("coll_pend", d_pend, 1'b0);
    check_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 4'h0, "coll");

    // Enable drop mid-dwell
    ticks(6);
    en = 1'b0;
    ticks(10);
    chk("en_off_sel", d_sel, 4'h0);
    chk("en_off_seg", d_seg, 7'h00);
    chk("en_off_inv_sel", i_sel, 4'hF);
    en = 1'b1;
    tick();
    chk("resume_sel0", d_sel, 4'b0010);
    chk("resume_seg0", d_seg, 7'h5B);
    tick();
    chk("resume_sel1", d_sel, 4'b0010);
    tick();
    chk("resume_dead", d_sel, 4'h0);
    tick();
    chk("resume_next", d_sel, 4'b0100);

    // Reset while a load is pending discards it
    do_load(16'h5555, 4'h0, 4'h0);
    ticks(2);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    chk("rst2_pend", d_pend, 1'b0);
    chk("rst2_sel", d_sel, 4'h0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("rst2_dark", d_seg, 7'h00);
    end
    chk("rst2_pend_end", d_pend, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
